// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch core.
// The optional lap feature in the top is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;
    localparam int MOD_DEC = 10;
    localparam int MOD_SEX = 6;

endpackage

// File: rtl/stopwatch_bcd_digit_cnt.sv
// One BCD digit counter with a configurable modulus.
// The carry output is combinational so a whole carry chain settles within one cycle.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter int MODULUS = MOD_DEC
)
(
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               i_inc,
    input  logic               i_clr,
    input  logic               i_loadZero,
    output logic [DIGIT_W-1:0] o_value,
    output logic               o_carry
);

    localparam logic [DIGIT_W-1:0] LAST = DIGIT_W'(MODULUS - 1);

    logic [DIGIT_W-1:0] r_value;
    logic               w_atLast;

    assign w_atLast = (r_value == LAST);
    assign o_carry  = i_inc && w_atLast;
    assign o_value  = r_value;

    // Zeroing from either clear or the max-time wrap takes priority over counting.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_value <= '0;
        end else if (i_clr || i_loadZero) begin
            r_value <= '0;
        end else if (i_inc) begin
            r_value <= w_atLast ? '0 : r_value + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// Stopwatch core: run/pause/clear FSM over a chain of five BCD digit counters.
// Define STOPWATCH_LAP_EN to add the lap freeze of the digit outputs.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int MIN_MAX = 59
)
(
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                tick_100ms,
    input  logic                start_stop,
    input  logic                clear,
    input  logic                lap,
    output logic [DIGIT_W-1:0]  tenths,
    output logic [DIGIT_W-1:0]  sec_ones,
    output logic [DIGIT_W-1:0]  sec_tens,
    output logic [DIGIT_W-1:0]  min_ones,
    output logic [DIGIT_W-1:0]  min_tens,
    output logic                running,
    output logic                overflow
);

    localparam logic [DIGIT_W-1:0] MAX_TENS = DIGIT_W'(MIN_MAX / 10);
    localparam logic [DIGIT_W-1:0] MAX_ONES = DIGIT_W'(MIN_MAX % 10);
    localparam logic [DIGIT_W-1:0] LAST_DEC = DIGIT_W'(MOD_DEC - 1);
    localparam logic [DIGIT_W-1:0] LAST_SEX = DIGIT_W'(MOD_SEX - 1);

    state_t r_state;
    logic   r_running;
    logic   r_overflow;

    logic w_count;
    logic w_atMax;
    logic w_wrap;

    logic [DIGIT_W-1:0] w_tenths;
    logic [DIGIT_W-1:0] w_secOnes;
    logic [DIGIT_W-1:0] w_secTens;
    logic [DIGIT_W-1:0] w_minOnes;
    logic [DIGIT_W-1:0] w_minTens;
    logic [5*DIGIT_W-1:0] w_liveDigits;

    logic w_cTenths;
    logic w_cSecOnes;
    logic w_cSecTens;
    logic w_cMinOnes;
    logic w_unusedMinTensCarry;

    // Counting follows the state at the start of the cycle; clear discards a coincident tick.
    assign w_count = tick_100ms && (r_state == RUN) && !clear;
    assign w_atMax = (w_minTens == MAX_TENS) && (w_minOnes == MAX_ONES) &&
                     (w_secTens == LAST_SEX) && (w_secOnes == LAST_DEC) &&
                     (w_tenths  == LAST_DEC);
    assign w_wrap  = w_count && w_atMax;

    assign w_liveDigits = {w_minTens, w_minOnes, w_secTens, w_secOnes, w_tenths};

    bcd_digit_cnt #(.MODULUS(MOD_DEC)) uTenths (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .i_inc(w_count), .i_clr(clear), .i_loadZero(w_wrap),
        .o_value(w_tenths), .o_carry(w_cTenths)
    );

    bcd_digit_cnt #(.MODULUS(MOD_DEC)) uSecOnes (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .i_inc(w_cTenths), .i_clr(clear), .i_loadZero(w_wrap),
        .o_value(w_secOnes), .o_carry(w_cSecOnes)
    );

    bcd_digit_cnt #(.MODULUS(MOD_SEX)) uSecTens (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .i_inc(w_cSecOnes), .i_clr(clear), .i_loadZero(w_wrap),
        .o_value(w_secTens), .o_carry(w_cSecTens)
    );

    bcd_digit_cnt #(.MODULUS(MOD_DEC)) uMinOnes (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .i_inc(w_cSecTens), .i_clr(clear), .i_loadZero(w_wrap),
        .o_value(w_minOnes), .o_carry(w_cMinOnes)
    );

    bcd_digit_cnt #(.MODULUS(MOD_DEC)) uMinTens (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .i_inc(w_cMinOnes), .i_clr(clear), .i_loadZero(w_wrap),
        .o_value(w_minTens), .o_carry(w_unusedMinTensCarry)
    );

    // Run/pause/clear control with registered status outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= IDLE;
            r_running  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_wrap;
            if (clear) begin
                r_state   <= IDLE;
                r_running <= 1'b0;
            end else if (start_stop) begin
                if (r_state == RUN) begin
                    r_state   <= PAUSE;
                    r_running <= 1'b0;
                end else begin
                    r_state   <= RUN;
                    r_running <= 1'b1;
                end
            end
        end
    end

    assign running  = r_running;
    assign overflow = r_overflow;

`ifdef STOPWATCH_LAP_EN
    logic                 r_lapHold;
    logic [5*DIGIT_W-1:0] r_lapDigits;

    // Lap snapshots the live count; a second lap, pausing or clearing releases it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_lapHold   <= 1'b0;
            r_lapDigits <= '0;
        end else if (clear) begin
            r_lapHold <= 1'b0;
        end else if ((r_state == RUN) && start_stop) begin
            r_lapHold <= 1'b0;
        end else if ((r_state == RUN) && lap) begin
            r_lapHold <= !r_lapHold;
            if (!r_lapHold) begin
                r_lapDigits <= w_liveDigits;
            end
        end
    end

    assign {min_tens, min_ones, sec_tens, sec_ones, tenths} =
        r_lapHold ? r_lapDigits : w_liveDigits;
`else
    logic w_unusedLap;

    assign w_unusedLap = lap;
    assign {min_tens, min_ones, sec_tens, sec_ones, tenths} = w_liveDigits;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench for stopwatch_bcd: a default instance and a MIN_MAX=1 instance share stimulus,
// checked against a tenths-count reference model, a directed table and corner sequences.
module tb_stopwatch_bcd;

    logic sys_clk;
    logic sys_rst_n;
    logic tick;
    logic startStop;
    logic clearIn;
    logic lapIn;

    logic [3:0] aTen, aSo, aSt, aMo, aMt;
    logic [3:0] bTen, bSo, bSt, bMo, bMt;
    logic       aRun, aOvf, bRun, bOvf;

    int vectors = 0;
    int miscompares = 0;

    int mT[2];
    int mMax[2] = '{59, 1};
    int frozen[2];
    bit hold[2];
    bit mOvf[2];
    int mMode;

    typedef struct {
        logic ss;
        logic clr;
        logic tk;
        int   expT;
        logic expRun;
    } vec_t;

    vec_t vecs[21];

    stopwatch_bcd dutLong (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tick_100ms(tick),
        .start_stop(startStop), .clear(clearIn), .lap(lapIn),
        .tenths(aTen), .sec_ones(aSo), .sec_tens(aSt), .min_ones(aMo), .min_tens(aMt),
        .running(aRun), .overflow(aOvf)
    );

    stopwatch_bcd #(.MIN_MAX(1)) dutShort (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tick_100ms(tick),
        .start_stop(startStop), .clear(clearIn), .lap(lapIn),
        .tenths(bTen), .sec_ones(bSo), .sec_tens(bSt), .min_ones(bMo), .min_tens(bMt),
        .running(bRun), .overflow(bOvf)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic logic [19:0] packBcd(int t);
        int m;
        int s;
        m = t / 600;
        s = (t / 10) % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mT[k] = 0;
            frozen[k] = 0;
            hold[k] = 1'b0;
            mOvf[k] = 1'b0;
        end
        mMode = 0;
    endtask

    // Elapsed time is a plain count of tenths; mode 0=idle, 1=run, 2=pause.
    task automatic modelStep();
        for (int k = 0; k < 2; k++) begin
            mOvf[k] = 1'b0;
            if (clearIn) begin
                mT[k] = 0;
                hold[k] = 1'b0;
            end else begin
`ifdef STOPWATCH_LAP_EN
                if (mMode == 1 && startStop) begin
                    hold[k] = 1'b0;
                end else if (mMode == 1 && lapIn) begin
                    if (hold[k]) begin
                        hold[k] = 1'b0;
                    end else begin
                        hold[k] = 1'b1;
                        frozen[k] = mT[k];
                    end
                end
`endif
                if (mMode == 1 && tick) begin
                    if (mT[k] == mMax[k] * 600 + 599) begin
                        mT[k] = 0;
                        mOvf[k] = 1'b1;
                    end else begin
                        mT[k] = mT[k] + 1;
                    end
                end
            end
        end
        if (clearIn) mMode = 0;
        else if (startStop) mMode = (mMode == 1) ? 2 : 1;
    endtask

    task automatic checkExp(input string name, input int k, input int expT,
                            input bit expRun, input bit expOvf);
        logic [21:0] act;
        logic [21:0] exp;
        if (k == 0) act = {aMt, aMo, aSt, aSo, aTen, aRun, aOvf};
        else        act = {bMt, bMo, bSt, bSo, bTen, bRun, bOvf};
        exp = {packBcd(expT), expRun, expOvf};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s dut%0d: got %h%h:%h%h.%h run=%b ovf=%b, want %h%h:%h%h.%h run=%b ovf=%b",
                     name, k, act[21:18], act[17:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
                     exp[21:18], exp[17:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic checkOutput(input string name);
        for (int k = 0; k < 2; k++) begin
            checkExp(name, k, hold[k] ? frozen[k] : mT[k], mMode == 1, mOvf[k]);
        end
    endtask

    task automatic applyStimulus(input logic ss, input logic clr, input logic tk, input logic lp);
        startStop = ss;
        clearIn = clr;
        tick = tk;
        lapIn = lp;
        @(posedge sys_clk);
        modelStep();
        #1;
        startStop = 1'b0;
        clearIn = 1'b0;
        tick = 1'b0;
        lapIn = 1'b0;
    endtask

    task automatic runTicks(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput(name);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        tick = 1'b0;
        startStop = 1'b0;
        clearIn = 1'b0;
        lapIn = 1'b0;
        modelReset();

        #12;
        for (int k = 0; k < 2; k++) checkExp("reset", k, 0, 1'b0, 1'b0);
        sys_rst_n = 1'b1;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 0, 1'b1};
        for (int i = 0; i < 10; i++) vecs[2 + i] = '{1'b0, 1'b0, 1'b1, i + 1, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 11, 1'b0};
        for (int i = 0; i < 5; i++) vecs[13 + i] = '{1'b0, 1'b0, 1'b1, 11, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 11, 1'b1};
        vecs[19] = '{1'b1, 1'b1, 1'b1, 0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 0, 1'b0};

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].ss, vecs[i].clr, vecs[i].tk, 1'b0);
            for (int k = 0; k < 2; k++) begin
                checkExp($sformatf("vec%0d", i), k, vecs[i].expT, vecs[i].expRun, 1'b0);
            end
        end

        // Minute carry, then wrap of the MIN_MAX=1 instance at 01:59.9.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start");
        runTicks(599, "count_up");
        for (int k = 0; k < 2; k++) checkExp("at_00:59.9", k, 599, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) checkExp("carry_01:00.0", k, 600, 1'b1, 1'b0);
        runTicks(599, "count_minute2");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkExp("long_02:00.0", 0, 1200, 1'b1, 1'b0);
        checkExp("short_wrap", 1, 0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkExp("long_hold", 0, 1200, 1'b1, 1'b0);
        checkExp("short_ovf_one_cycle", 1, 0, 1'b1, 1'b0);

        // Clear beats coincident start_stop and tick.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runTicks(123, "count_12.3");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) checkExp("clear_priority", k, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) checkExp("idle_ignores_tick", k, 0, 1'b0, 1'b0);

        // Asynchronous reset mid-count at 03:45.6.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runTicks(2256, "count_03:45.6");
        checkExp("long_03:45.6", 0, 2256, 1'b1, 1'b0);
        checkExp("short_01:45.6", 1, 1056, 1'b1, 1'b0);
        #3 sys_rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) checkExp("async_reset", k, 0, 1'b0, 1'b0);
        modelReset();
        #1 sys_rst_n = 1'b1;
        runTicks(3, "ticks_after_reset");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) checkExp("restart_ignores_tick", k, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) checkExp("restart_counts", k, 1, 1'b1, 1'b0);

`ifdef STOPWATCH_LAP_EN
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runTicks(20, "count_02.0");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) checkExp("lap_freeze", k, 20, 1'b1, 1'b0);
        runTicks(7, "lap_hold_model");
        for (int k = 0; k < 2; k++) checkExp("lap_hold", k, 20, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) checkExp("lap_release", k, 27, 1'b1, 1'b0);
`endif

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("pre_random_clear");
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic lp;
            r = $urandom_range(0, 199);
            lp = 1'b0;
`ifdef STOPWATCH_LAP_EN
            lp = ($urandom_range(0, 29) == 0);
`endif
            applyStimulus(r < 4, r >= 198, $urandom_range(0, 3) != 0, lp);
            checkOutput("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Stopwatch core that consumes the single-cycle 100 ms tick from the team's tick-generator stage and accumulates elapsed time as BCD digits (minutes, seconds, tenths) under run/pause/clear control. It sits between the tick generator and the 7-segment/display driver. All count and status outputs are registered and drive the display path directly.

## Interface
Parameters:
- MIN_MAX, default 59: highest minute value before wrap; legal range 1..99.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- tick_100ms  in  1  single-cycle pulse, one every 100 ms, from the tick generator.
- start_stop  in  1  single-cycle pulse from the debounced key; toggles run/pause.
- clear  in  1  single-cycle pulse; returns to zero and IDLE.
- lap  in  1  single-cycle pulse; lap freeze/release (only with STOPWATCH_LAP_EN).
- tenths  out  4  BCD 0..9.
- sec_ones  out  4  BCD 0..9.
- sec_tens  out  4  BCD 0..5.
- min_ones  out  4  BCD 0..9.
- min_tens  out  4  BCD 0..9 (bounded by MIN_MAX).
- running  out  1  high while in RUN.
- overflow  out  1  one-cycle pulse on wrap from max time to zero.

## Operation
- FSM states: IDLE (stopped at zero), RUN, PAUSE.
- IDLE + start_stop -> RUN. RUN + start_stop -> PAUSE. PAUSE + start_stop -> RUN.
- clear in any state -> IDLE; all digits zero; lap hold released.
- Input priority within one cycle: clear > start_stop > tick_100ms.
- Counting is gated by the state at the start of the cycle: a tick coinciding with start_stop in RUN is counted; a tick coinciding with start_stop in PAUSE/IDLE is ignored; a tick coinciding with clear is discarded.
- Ticks in IDLE or PAUSE are ignored; digits hold.
- Carry chain per counted tick: tenths 9->0 carries to sec_ones; sec_ones 9->0 to sec_tens; sec_tens 5->0 to min_ones; min_ones 9->0 to min_tens.
- Maximum time is MIN_MAX:59.9. The next counted tick sets all digits to 0, pulses overflow, and the FSM stays in RUN.
- Digits never leave their legal BCD range. Minutes never exceed MIN_MAX.

## Timing
- Reset values: all digits 0, running 0, overflow 0, state IDLE, lap hold cleared.
- Tick sampled in cycle N: updated digits are visible in cycle N+1.
- start_stop in cycle N: running changes in cycle N+1.
- clear in cycle N: digits read zero and running is 0 in cycle N+1.
- overflow is high for exactly the cycle in which the wrapped zero digits first appear.
- Reset asserted mid-count returns all outputs to reset values immediately, independent of the clock.
- Back-to-back ticks on consecutive cycles (test benches) are each counted; no minimum tick spacing is required.

## Configuration
- STOPWATCH_LAP_EN defined:
  - In RUN, a lap pulse freezes the digit outputs at the current value while internal counting continues.
  - A second lap pulse, or start_stop into PAUSE, releases the freeze; outputs then track the live count from the next cycle.
  - lap in IDLE or PAUSE is ignored.
  - Frozen outputs update one cycle after the lap pulse.
- STOPWATCH_LAP_EN undefined:
  - lap is ignored.
  - Digit outputs always show the live count.
  - No lap registers are instantiated.

## Structure
- Package stopwatch_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2);
  - the BCD digit width constant (4);
  - digit modulus constants (10, 6).
- Sub-module bcd_digit_cnt: one BCD digit with a modulus parameter, inputs inc, clr and load-zero, and outputs value plus carry (asserted when inc at modulus-1). It is instantiated five times; min_tens/min_ones wrap is handled by the top-level MIN_MAX compare.

## Test plan
- Reset, then start_stop, then 10 ticks: digits read 00:01.0 and running=1.
- RUN, start_stop coincident with a tick: the count advances by 1, then PAUSE; 5 further ticks leave the digits unchanged.
- Count to 00:59.9, then 1 tick: digits read 01:00.0. With MIN_MAX=1, count to 01:59.9, then 1 tick: digits read 00:00.0, overflow high for 1 cycle, running stays 1.
- RUN at 00:12.3, clear coincident with a tick and a start_stop: next cycle digits read 00:00.0, state IDLE, running=0.
- sys_rst_n pulsed low mid-count at 03:45.6: outputs read zero asynchronously; after release, ticks are ignored until start_stop.
- STOPWATCH_LAP_EN: lap at 00:02.0, then 7 ticks: outputs hold 00:02.0; second lap: outputs show 00:02.7.
